// File: rtl/seq_fsm_pattern2_pkg.sv
// Shared definitions for the 1110 pattern detector.
// State encoding is binary. Values 5..7 are unused and recover to STATE_A.
package seq_fsm_pattern2_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    STATE_A = 3'd0,  // idle, no useful history
    STATE_B = 3'd1,  // seen 1
    STATE_C = 3'd2,  // seen 11
    STATE_D = 3'd3,  // seen 111 or more
    STATE_E = 3'd4   // 1110 just completed, detect asserted
  } state_e;

endpackage

// File: rtl/seq_fsm_pattern2_state_reg.sv
// Generic state register with a synchronous active-low reset to a
// programmable value.
module seq_fsm_pattern2_state_reg #(
  parameter int              W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // Capture next state each edge; reset overrides the incoming value.
  always_ff @(posedge clk) begin
    if (!rst_b) q_o <= RST_VAL;
    else        q_o <= d_i;
  end

endmodule

// File: rtl/seq_fsm_pattern2.sv
// Moore detector for the serial pattern 1110 (three or more 1s followed by
// a 0). out pulses for one cycle while the FSM sits in STATE_E.
//
//   state | meaning
//   A     | idle, no useful history
//   B     | seen 1
//   C     | seen 11
//   D     | seen 111 or more (long runs of 1 stay here)
//   E     | 1110 just completed; out = 1, leaves unconditionally
module seq_fsm_pattern2
  import seq_fsm_pattern2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in_,
  output logic out
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;

  seq_fsm_pattern2_state_reg #(
    .W       (STATE_W),
    .RST_VAL (STATE_A)
  ) u_state_reg (
    .clk   (clk),
    .rst_b (reset),
    .d_i   (state_d),
    .q_o   (state_q)
  );

  // Next-state and output decode; unused encodings fall back to A with out low.
  always_comb begin
    state_d = STATE_A;
    out     = 1'b0;
    case (state_q)
      STATE_A: state_d = in_ ? STATE_B : STATE_A;
      STATE_B: state_d = in_ ? STATE_C : STATE_A;
      STATE_C: state_d = in_ ? STATE_D : STATE_A;
      STATE_D: state_d = in_ ? STATE_D : STATE_E;
      STATE_E: begin
        // The trailing 0 is consumed by the detect; a new 1 starts over at B.
        state_d = in_ ? STATE_B : STATE_A;
        out     = 1'b1;
      end
      default: state_d = STATE_A;
    endcase
  end

  // A detect lasts a single cycle.
  a_out_pulse : assert property (@(posedge clk) out |=> !out);

  // A detect is only reachable from D after sampling a 0 out of reset.
  a_out_from_d : assert property (@(posedge clk)
    out |-> ($past(state_q) == STATE_D && !$past(in_) && $past(reset)));

endmodule

// File: tb/tb_seq_fsm_pattern2.sv
// Bench for seq_fsm_pattern2: directed sequences plus random stimulus,
// compared every cycle against a run-length reference model.
module tb_seq_fsm_pattern2;
  import seq_fsm_pattern2_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic in_;
  logic out;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: length of the current run of 1s (saturates at 3)
  int     ones;
  bit     exp_out;
  state_e exp_st;
  state_e prev_st;
  bit     prev_in;
  bit     prev_rst;

  seq_fsm_pattern2 dut (
    .clk   (clk),
    .reset (reset),
    .in_   (in_),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic state_e model_state(input int run, input bit det);
    if (det)           return STATE_E;
    else if (run == 0) return STATE_A;
    else if (run == 1) return STATE_B;
    else if (run == 2) return STATE_C;
    else               return STATE_D;
  endfunction

  // drive one cycle, advance the model at the edge, check 1 ns later
  task automatic cycle(input bit rst_b, input bit d, input string tag);
    reset = rst_b;
    in_   = d;
    prev_st  = exp_st;
    prev_in  = d;
    prev_rst = rst_b;
    @(posedge clk);
    if (!rst_b) begin
      ones    = 0;
      exp_out = 1'b0;
    end else begin
      exp_out = (d == 1'b0) && (ones >= 3);
      ones    = d ? ((ones >= 3) ? 3 : ones + 1) : 0;
    end
    exp_st = model_state(ones, exp_out);
    #1;
    chk({tag, "_out"},   32'(out),         32'(exp_out));
    chk({tag, "_state"}, 32'(dut.state_q), 32'(exp_st));
    if (out === 1'b1)
      chk({tag, "_from_d"}, {30'd0, prev_st == STATE_D, !prev_in && prev_rst}, 32'd3);
  endtask

  task automatic run_seq(input string tag, input bit seq[$]);
    foreach (seq[i]) cycle(1'b1, seq[i], tag);
  endtask

  initial begin
    bit s[$];
    int pulses;
    ones    = 0;
    exp_out = 1'b0;
    exp_st  = STATE_A;
    reset   = 1'b0;
    in_     = 1'b0;

    cycle(1'b0, 1'b1, "rst");

    s = '{0, 1, 0, 1, 1, 0};
    run_seq("reject", s);

    cycle(1'b0, 1'b0, "rst2");
    s = '{1, 1, 1, 1, 0, 0};
    run_seq("long_run", s);

    cycle(1'b0, 1'b0, "rst3");
    pulses = 0;
    s = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
    foreach (s[i]) begin
      cycle(1'b1, s[i], "b2b");
      if (out === 1'b1) pulses++;
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);

    cycle(1'b0, 1'b0, "rst4");
    s = '{1, 1, 1, 1, 0};
    run_seq("pre_rst", s);
    chk("in_e", 32'(dut.state_q), 32'(STATE_E));
    cycle(1'b0, 1'b1, "rst_in_e");
    s = '{0, 1, 0};
    run_seq("post_rst", s);

    for (int i = 0; i < 40; i++) cycle(1'b1, 1'($urandom_range(0, 1)), "rand");
    for (int i = 0; i < 20; i++)
      cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), "rand_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
